// File: rtl/iiitb_sevenseg_scan_if.sv
// Signal bundle between the clock block, the seven-segment scanner and the display pins.
// master drives the BCD digits and Alarm; slave is the scanner that returns an/seg/dp.
interface iiitb_sevenseg_scan_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic [3:0] S_in1;
  logic [3:0] S_in0;
  logic       Alarm;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output H_in1, H_in0, M_in1, M_in0, S_in1, S_in0, Alarm,
    input  an, seg, dp
  );

  modport slave (
    input  H_in1, H_in0, M_in1, M_in0, S_in1, S_in0, Alarm,
    output an, seg, dp
  );
endinterface

// File: rtl/iiitb_sevenseg_scan.sv
// Six-digit common-anode 7-segment scanner with per-frame snapshot and leading-hour blanking.
// Optional macro ALARM_BLINK_EN blanks the whole display at BLINK_TICKS half-period while Alarm=1.
module iiitb_sevenseg_scan #(
  parameter int unsigned DIGIT_TICKS = 50000,
  parameter int unsigned BLINK_TICKS = 25000000
) (
  input logic                  clk,
  input logic                  reset,
  iiitb_sevenseg_scan_if.slave bus
);

  localparam int unsigned PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [PW-1:0] r_presc;
  logic          r_run;
  logic [2:0]    r_idx;
  logic [1:0]    r_h1;
  logic [3:0]    r_h0, r_m1, r_m0, r_s1, r_s0;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tc;
  logic          w_wrap;
  logic [2:0]    w_nidx;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  logic [5:0]    w_an;
  logic          w_dp;

  assign w_tc   = (r_presc == PW'(DIGIT_TICKS - 1));
  assign w_wrap = !r_run || (r_idx == 3'd5);
  assign w_nidx = w_wrap ? 3'd0 : r_idx + 3'd1;
  assign w_an   = ~(6'b000001 << w_nidx);
  assign w_dp   = !((w_nidx == 3'd2) || (w_nidx == 3'd4));

  // idx 0 is only reached on a wrap, the same edge that snapshots, so it reads the live S0.
  always_comb begin
    w_digit = '0;
    case (w_nidx)
      3'd0:    w_digit = bus.S_in0;
      3'd1:    w_digit = r_s1;
      3'd2:    w_digit = r_m0;
      3'd3:    w_digit = r_m1;
      3'd4:    w_digit = r_h0;
      3'd5:    w_digit = {2'b00, r_h1};
      default: w_digit = '0;
    endcase

    w_seg = SEG_DASH;
    case (w_digit)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = SEG_DASH;
    endcase

    if (w_nidx == 3'd5) begin
      if (r_h1 == 2'd0)      w_seg = SEG_BLANK;
      else if (r_h1 == 2'd3) w_seg = SEG_DASH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_run   <= 1'b0;
      r_idx   <= '0;
      r_h1    <= '0;
      r_h0    <= '0;
      r_m1    <= '0;
      r_m0    <= '0;
      r_s1    <= '0;
      r_s0    <= '0;
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + 1'b1;
      if (w_tc) begin
        r_run <= 1'b1;
        r_idx <= w_nidx;
        r_an  <= w_an;
        r_seg <= w_seg;
        r_dp  <= w_dp;
        if (w_wrap) begin
          r_h1 <= bus.H_in1;
          r_h0 <= bus.H_in0;
          r_m1 <= bus.M_in1;
          r_m0 <= bus.M_in0;
          r_s1 <= bus.S_in1;
          r_s0 <= bus.S_in0;
        end
      end
    end
  end

`ifdef ALARM_BLINK_EN
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BW-1:0] r_bcnt;
  logic          r_phase;

  always_ff @(posedge clk) begin
    if (reset || !bus.Alarm) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  // Blanking is applied after the scan registers so scanning and snapshots never pause.
  assign bus.an  = r_phase ? r_an  : '1;
  assign bus.seg = r_phase ? r_seg : SEG_BLANK;
  assign bus.dp  = r_phase ? r_dp  : 1'b1;
`else
  localparam int unsigned unused_blink_ticks = BLINK_TICKS;
  logic w_unused_alarm;

  assign w_unused_alarm = bus.Alarm;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
`endif

endmodule
